// File: rtl/sel_mul_pkg.sv
// Shared width helpers and product extension for the selector/multiplier datapath.
// Widths are computed here so the top and the selector agree on SEL_W.
package sel_mul_pkg;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int sel_w_f(input int num_ch);
        return clog2_f(num_ch);
    endfunction

    function automatic int prod_w_f(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int res_w_f(input int data_w, input int guard);
        return 2 * data_w + guard;
    endfunction

    // Sign- or zero-extends the low prod_w bits of p to 64 bits.
    function automatic logic [63:0] ext_prod(input logic [63:0] p, input int prod_w, input bit sgn);
        logic [63:0] r;
        r = p;
        for (int i = 0; i < 64; i++) begin
            if (i >= prod_w) r[i] = sgn ? p[prod_w-1] : 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sel_mux_n.sv
// NUM_CH:1 operand selector; an index with no matching channel yields zero.
// Latency: combinational. Backpressure: none (pure function of bus and sel).
// Handshake is owned by the instantiating pipeline.
import sel_mul_pkg::*;

module sel_mux_n #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    localparam int SEL_W = sel_w_f(NUM_CH)
) (
    input  logic [NUM_CH*DATA_W-1:0] bus,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        dat
);

    always_comb begin
        dat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) dat = bus[k*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/sel_mul_pipe.sv
// Two-channel-select multiplier (optional MAC when SEL_MUL_ACCUM_EN is defined), 2-stage valid/ready pipe.
// Latency: accept at cycle N -> out_valid at N+2; throughput 1/cycle.
// Backpressure: in_ready = !out_valid || out_ready; a stalled output freezes both stages.
import sel_mul_pkg::*;

module sel_mul_pipe #(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 8,
    parameter int SIGNED    = 0,
    parameter int ACC_GUARD = 4,
    localparam int SEL_W    = sel_w_f(NUM_CH),
    localparam int PROD_W   = prod_w_f(DATA_W),
    localparam int RES_W    = res_w_f(DATA_W, ACC_GUARD)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] a_bus,
    input  logic [NUM_CH*DATA_W-1:0] b_bus,
    input  logic [SEL_W-1:0]         sel_a,
    input  logic [SEL_W-1:0]         sel_b,
    input  logic                     acc_clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         result
);

    logic              advance;
    logic [DATA_W-1:0] mux_a, mux_b;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic              s1_valid;
    logic [PROD_W-1:0] op_a_x, op_b_x, prod;
    logic [RES_W-1:0]  res_ext, s2_next;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    sel_mux_n #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) u_mux_a (.bus(a_bus), .sel(sel_a), .dat(mux_a));
    sel_mux_n #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) u_mux_b (.bus(b_bus), .sel(sel_b), .dat(mux_b));

    // Low PROD_W bits of a full-width product are identical for signed and unsigned once extended.
    always_comb begin
        if (SIGNED != 0) begin
            op_a_x = {{DATA_W{s1_a[DATA_W-1]}}, s1_a};
            op_b_x = {{DATA_W{s1_b[DATA_W-1]}}, s1_b};
        end else begin
            op_a_x = {{DATA_W{1'b0}}, s1_a};
            op_b_x = {{DATA_W{1'b0}}, s1_b};
        end
        prod = op_a_x * op_b_x;
    end

    assign res_ext = RES_W'(ext_prod(64'(prod), PROD_W, SIGNED != 0));

`ifdef SEL_MUL_ACCUM_EN
    logic s1_clr;

    always_ff @(posedge clk) begin
        if (rst)                       s1_clr <= 1'b0;
        else if (advance && in_valid)  s1_clr <= acc_clr;
    end

    // result doubles as the accumulator: it only changes on valid S2 loads.
    assign s2_next = (s1_clr ? '0 : result) + res_ext;
`else
    logic unused_clr;
    assign unused_clr = acc_clr;
    assign s2_next    = res_ext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a <= mux_a;
                s1_b <= mux_b;
            end
            out_valid <= s1_valid;
            if (s1_valid) result <= s2_next;
        end
    end

endmodule

// File: tb/tb_sel_mul_pipe.sv
// Scoreboard bench: dut0 unsigned 8 channels, dut1 signed 6 channels, sharing handshake and low channels.
module tb_sel_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, acc_clr, in_valid, out_ready;
    logic [2:0]  sel_a, sel_b;
    logic [63:0] a8, b8;
    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [19:0] result0, result1;
    logic [7:0]  ach [8];
    logic [7:0]  bch [8];

    for (genvar k = 0; k < 8; k++) begin : g_pack
        assign a8[k*8 +: 8] = ach[k];
        assign b8[k*8 +: 8] = bch[k];
    end

    sel_mul_pipe #(.DATA_W(8), .NUM_CH(8), .SIGNED(0), .ACC_GUARD(4)) dut0 (
        .clk(clk), .rst(rst), .a_bus(a8), .b_bus(b8), .sel_a(sel_a), .sel_b(sel_b),
        .acc_clr(acc_clr), .in_valid(in_valid), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_ready(out_ready), .result(result0));

    sel_mul_pipe #(.DATA_W(8), .NUM_CH(6), .SIGNED(1), .ACC_GUARD(4)) dut1 (
        .clk(clk), .rst(rst), .a_bus(a8[47:0]), .b_bus(b8[47:0]), .sel_a(sel_a), .sel_b(sel_b),
        .acc_clr(acc_clr), .in_valid(in_valid), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_ready(out_ready), .result(result1));

`ifdef SEL_MUL_ACCUM_EN
    localparam logic [19:0] EXP_B2 = 20'd26;
    localparam logic [19:0] EXP_B3 = 20'd27;
`else
    localparam logic [19:0] EXP_B2 = 20'd20;
    localparam logic [19:0] EXP_B3 = 20'd1;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [19:0] q0 [$];
    logic [19:0] q1 [$];
    logic [19:0] acc0 = '0;
    logic [19:0] acc1 = '0;
    bit          rnd_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] mod_u(input logic [7:0] a, input logic [7:0] b);
        return 20'(a) * 20'(b);
    endfunction

    function automatic logic [19:0] mod_s(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return 20'(p);
    endfunction

    // Presents one beat, waits for acceptance, pushes expected results; leaves in_valid high.
    task automatic send(input logic [2:0] sa, input logic [2:0] sb, input logic clr);
        logic [7:0]  oa1, ob1;
        logic [19:0] e0, e1;
        bit          ok;
        ok      = 1'b0;
        sel_a   = sa;
        sel_b   = sb;
        acc_clr = clr;
        in_valid = 1'b1;
        oa1 = (sa < 3'd6) ? ach[sa] : 8'h00;
        ob1 = (sb < 3'd6) ? bch[sb] : 8'h00;
        e0  = mod_u(ach[sa], bch[sb]);
        e1  = mod_s(oa1, ob1);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready0;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
`ifdef SEL_MUL_ACCUM_EN
            acc0 = (clr ? 20'd0 : acc0) + e0;
            acc1 = (clr ? 20'd0 : acc1) + e1;
            e0 = acc0;
            e1 = acc1;
`endif
            q0.push_back(e0);
            q1.push_back(e1);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && out_ready === 1'b1) begin
            if (out_valid0 === 1'b1) begin
                if (q0.size() == 0) chk("extra_beat0", 32'd1, 32'd0);
                else chk("res0", 32'(result0), 32'(q0.pop_front()));
            end
            if (out_valid1 === 1'b1) begin
                if (q1.size() == 0) chk("extra_beat1", 32'd1, 32'd0);
                else chk("res1", 32'(result1), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        sel_a = '0; sel_b = '0;
        for (int k = 0; k < 8; k++) begin ach[k] = 8'h00; bch[k] = 8'h00; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 32'(out_valid0), 32'd0);
        chk("rst_res", 32'(result0), 32'd0);
        chk("rst_rdy", 32'(in_ready0), 32'd1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Unsigned max product and two-cycle latency
        ach[3] = 8'hFF; bch[5] = 8'hFF;
        send(3'd3, 3'd5, 1'b1);
        idle();
        chk("lat_s1", 32'(out_valid0), 32'd0);
        @(posedge clk); #1;
        chk("lat_s2", 32'(out_valid0), 32'd1);
        chk("u_ff", 32'(result0), 32'h0FE01);

        // Signed -128 * 127
        ach[1] = 8'h80; bch[2] = 8'h7F;
        send(3'd1, 3'd2, 1'b1);
        idle();
        @(posedge clk); #1;
        chk("s_vld", 32'(out_valid1), 32'd1);
        chk("s_neg", 32'(result1), 32'hFC080);

        // Out-of-range select on the 6-channel instance
        ach[7] = 8'h12;
        send(3'd7, 3'd5, 1'b1);
        idle();
        @(posedge clk); #1;
        chk("oor_vld", 32'(out_valid1), 32'd1);
        chk("oor_res", 32'(result1), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Accumulate sequence, back to back
        ach[0] = 8'd2; bch[0] = 8'd3; ach[1] = 8'd4; bch[1] = 8'd5;
        ach[2] = 8'd1; bch[2] = 8'd1; ach[4] = 8'd2; bch[4] = 8'd2;
        send(3'd0, 3'd0, 1'b1);
        send(3'd1, 3'd1, 1'b0);
        chk("mac_b1", 32'(result0), 32'd6);
        send(3'd2, 3'd2, 1'b0);
        chk("mac_b2", 32'(result0), 32'(EXP_B2));
        send(3'd4, 3'd4, 1'b1);
        idle();
        chk("mac_b3", 32'(result0), 32'(EXP_B3));
        @(posedge clk); #1;
        chk("mac_b4", 32'(result0), 32'd4);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: 4 beats, output stalled 5 cycles
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    for (int k = 0; k < 8; k++) begin
                        ach[k] = 8'($urandom); bch[k] = 8'($urandom);
                    end
                    send(3'($urandom_range(7)), 3'($urandom_range(7)), 1'b0);
                end
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #2 out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("bp_rdy", 32'(in_ready0), 32'd0);
                    chk("bp_vld", 32'(out_valid0), 32'd1);
                    chk("bp_res", 32'(result0), 32'(q0[0]));
                    @(posedge clk);
                end
                #2 out_ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;

        // Random stream with random consumer stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    for (int k = 0; k < 8; k++) begin
                        ach[k] = 8'($urandom); bch[k] = 8'($urandom);
                    end
                    send(3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1)));
                end
                idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2 out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;

        // Reset mid-stream with in_valid still high
        send(3'd1, 3'd1, 1'b0);
        send(3'd2, 3'd2, 1'b0);
        rst = 1'b1;
        out_ready = 1'b0;
        q0.delete(); q1.delete();
        acc0 = '0; acc1 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        chk("mrst_vld0", 32'(out_valid0), 32'd0);
        chk("mrst_vld1", 32'(out_valid1), 32'd0);
        chk("mrst_res0", 32'(result0), 32'd0);
        chk("mrst_rdy", 32'(in_ready0), 32'd1);
        @(posedge clk); #1;
        chk("mrst_ghost1", 32'(out_valid0), 32'd0);
        @(posedge clk); #1;
        chk("mrst_ghost2", 32'(out_valid0), 32'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        chk("q0_drain", 32'(q0.size()), 32'd0);
        chk("q1_drain", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
